// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the two-port cache/memory arbiter.
// Optional build macro: CACHE_ARB_FIXED_PRIO_EN (consumed by cache_arb_rr_pick).
package cache_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam logic [1:0] GRANT_NONE = 2'b00;

  localparam int DEF_DATA_WIDTH         = 32;
  localparam int DEF_INDEX_WIDTH        = 9;
  localparam int DEF_BLOCK_OFFSET_WIDTH = 2;
  localparam int DEF_TAG_WIDTH          = 21 - DEF_INDEX_WIDTH - DEF_BLOCK_OFFSET_WIDTH;
  // Extra bit: memory is addressed in 2-byte units.
  localparam int DEF_MEM_ADDR_WIDTH     = DEF_TAG_WIDTH + DEF_INDEX_WIDTH + DEF_BLOCK_OFFSET_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  function automatic logic [1:0] state_grant(input arb_state_e s);
    case (s)
      GRANT0:  return 2'b01;
      GRANT1:  return 2'b10;
      default: return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_rr_pick.sv
// Combinational two-requester picker returning a one-hot winner.
// CACHE_ARB_FIXED_PRIO_EN defined: port 0 wins ties; otherwise round-robin on last_owner.
module cache_arb_rr_pick
  import cache_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_owner,
  output logic [NUM_PORTS-1:0] win
);

`ifdef CACHE_ARB_FIXED_PRIO_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    win = req;
    if (req == 2'b11) win = 2'b01;
  end
`else
  always_comb begin
    win = req;
    if (req == 2'b11) win = last_owner ? 2'b01 : 2'b10;
  end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one burst memory port between two d_cache instances; a grant lasts one full burst.
// Build option CACHE_ARB_FIXED_PRIO_EN selects fixed port-0 priority instead of round-robin.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH        = DEF_INDEX_WIDTH,
  parameter int BLOCK_OFFSET_WIDTH = DEF_BLOCK_OFFSET_WIDTH,
  parameter int TAG_WIDTH          = 21 - INDEX_WIDTH - BLOCK_OFFSET_WIDTH,
  parameter int MEM_ADDR_WIDTH     = TAG_WIDTH + INDEX_WIDTH + BLOCK_OFFSET_WIDTH + 1
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset_n,
  input  logic                      i_C0_MEM_Valid,
  input  logic                      i_C0_MEM_Read_Write_n,
  input  logic [MEM_ADDR_WIDTH-1:0] i_C0_MEM_Address,
  input  logic [DATA_WIDTH-1:0]     i_C0_MEM_Data,
  input  logic                      i_C1_MEM_Valid,
  input  logic                      i_C1_MEM_Read_Write_n,
  input  logic [MEM_ADDR_WIDTH-1:0] i_C1_MEM_Address,
  input  logic [DATA_WIDTH-1:0]     i_C1_MEM_Data,
  output logic                      o_C0_MEM_Valid,
  output logic                      o_C0_MEM_Data_Read,
  output logic                      o_C0_MEM_Last,
  output logic [DATA_WIDTH-1:0]     o_C0_MEM_Data,
  output logic                      o_C1_MEM_Valid,
  output logic                      o_C1_MEM_Data_Read,
  output logic                      o_C1_MEM_Last,
  output logic [DATA_WIDTH-1:0]     o_C1_MEM_Data,
  output logic                      o_MEM_Valid,
  output logic                      o_MEM_Read_Write_n,
  output logic [MEM_ADDR_WIDTH-1:0] o_MEM_Address,
  output logic [DATA_WIDTH-1:0]     o_MEM_Data,
  input  logic                      i_MEM_Valid,
  input  logic                      i_MEM_Data_Read,
  input  logic                      i_MEM_Last,
  input  logic [DATA_WIDTH-1:0]     i_MEM_Data,
  output logic [1:0]                o_Grant,
  output logic                      o_Busy
);

  arb_state_e state_reg, state_next;
  logic [1:0] grant_reg, grant_next;
  logic       last_owner_reg, last_owner_next;
  logic [NUM_PORTS-1:0] req, win;
  logic       burst_end;

  logic [NUM_PORTS-1:0]      port_rw_n;
  logic [MEM_ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
  logic [DATA_WIDTH-1:0]     port_wdata [NUM_PORTS];
  logic [NUM_PORTS-1:0]      rsp_valid, rsp_data_read, rsp_last;
  logic [DATA_WIDTH-1:0]     rsp_data [NUM_PORTS];

  assign req           = {i_C1_MEM_Valid, i_C0_MEM_Valid};
  assign port_rw_n     = {i_C1_MEM_Read_Write_n, i_C0_MEM_Read_Write_n};
  assign port_addr[0]  = i_C0_MEM_Address;
  assign port_addr[1]  = i_C1_MEM_Address;
  assign port_wdata[0] = i_C0_MEM_Data;
  assign port_wdata[1] = i_C1_MEM_Data;

  // A beat ends the burst on either the read or the write handshake.
  assign burst_end = i_MEM_Last & (i_MEM_Valid | i_MEM_Data_Read);

  cache_arb_rr_pick u_pick (
    .req        (req),
    .last_owner (last_owner_reg),
    .win        (win)
  );

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      IDLE: begin
        if (win[0]) begin
          state_next      = GRANT0;
          last_owner_next = 1'b0;
        end else if (win[1]) begin
          state_next      = GRANT1;
          last_owner_next = 1'b1;
        end
      end
      GRANT0: begin
        if (burst_end)            state_next = RELEASE;
        else if (!i_C0_MEM_Valid) state_next = IDLE;
      end
      GRANT1: begin
        if (burst_end)            state_next = RELEASE;
        else if (!i_C1_MEM_Valid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    grant_next = state_grant(state_next);
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_reg      <= IDLE;
      grant_reg      <= GRANT_NONE;
      last_owner_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_owner_reg <= last_owner_next;
    end
  end

  // grant_reg is zero in IDLE and RELEASE, so it gates every routed path.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_route
    assign rsp_valid[gi]     = grant_reg[gi] & i_MEM_Valid;
    assign rsp_data_read[gi] = grant_reg[gi] & i_MEM_Data_Read;
    assign rsp_last[gi]      = grant_reg[gi] & i_MEM_Last;
    assign rsp_data[gi]      = grant_reg[gi] ? i_MEM_Data : '0;
  end

  always_comb begin
    o_MEM_Valid        = 1'b0;
    o_MEM_Read_Write_n = 1'b0;
    o_MEM_Address      = '0;
    o_MEM_Data         = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_reg[p]) begin
        o_MEM_Valid        = req[p];
        o_MEM_Read_Write_n = port_rw_n[p];
        o_MEM_Address      = port_addr[p];
        o_MEM_Data         = port_wdata[p];
      end
    end
  end

  assign o_C0_MEM_Valid     = rsp_valid[0];
  assign o_C0_MEM_Data_Read = rsp_data_read[0];
  assign o_C0_MEM_Last      = rsp_last[0];
  assign o_C0_MEM_Data      = rsp_data[0];
  assign o_C1_MEM_Valid     = rsp_valid[1];
  assign o_C1_MEM_Data_Read = rsp_data_read[1];
  assign o_C1_MEM_Last      = rsp_last[1];
  assign o_C1_MEM_Data      = rsp_data[1];

  assign o_Grant = grant_reg;
  assign o_Busy  = (state_reg != IDLE);

endmodule
